// File: rtl/led7seg_pkg.sv
// rtl/led7seg_pkg.sv - glyph table, segment positions and counter width for led7seg_capture
package led7seg_pkg;

  localparam int CNT_W = 4;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Active-high g..a patterns; entry i is the glyph for nibble i.
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,
    7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,
    7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
    7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
  };

endpackage

// File: rtl/led7seg_decode.sv
// rtl/led7seg_decode.sv - combinational seven-segment pattern to hex nibble lookup
module led7seg_decode
  import led7seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       match
);

  always_comb begin
    nibble = '0;
    match  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == GLYPH_TABLE[i]) begin
        nibble = 4'(i);
        match  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led7seg_capture.sv
// rtl/led7seg_capture.sv - multiplexed 7-seg bus capture with stability filter; LED7SEG_DP_EN adds dp tracking
module led7seg_capture
  import led7seg_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3,
  parameter int SAMPLE_DIV = 16
) (
  input  logic                clk,
  input  logic                _reset,
`ifdef LED7SEG_DP_EN
  input  logic [7:0]          _segments,
`else
  input  logic [6:0]          _segments,
`endif
  input  logic [DIGITS-1:0]   _digit_sel,
  output logic [4*DIGITS-1:0] value,
  output logic [DIGITS-1:0]   digit_valid,
  output logic                update,
  output logic                error
`ifdef LED7SEG_DP_EN
  ,
  output logic [DIGITS-1:0]   dp
`endif
);

`ifdef LED7SEG_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [15:0]      DIV_MAX = 16'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] STAB_M1 = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic rst_s1_q, rst_s2_q, rst_n;
  logic [SEG_W-1:0]    seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
  logic [DIGITS-1:0]   sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
  logic [15:0]         div_q, div_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SEG_W-1:0]    pat_q, pat_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic                update_q, update_d, error_q, error_d;
`ifdef LED7SEG_DP_EN
  logic [DIGITS-1:0]   dp_q, dp_d;
`endif

  logic [SEG_W-1:0]  seg_hi;
  logic [DIGITS-1:0] sel_hi;
  logic [IDX_W-1:0]  idx;
  logic              qual, strobe, accept, match;
  logic [3:0]        nibble;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      rst_s1_q <= 1'b0;
      rst_s2_q <= 1'b0;
    end else begin
      rst_s1_q <= 1'b1;
      rst_s2_q <= rst_s1_q;
    end
  end
  assign rst_n = rst_s2_q;

  assign seg_hi = ~seg_s2_q;
  assign sel_hi = ~sel_s2_q;
  assign qual   = $onehot(sel_hi);
  assign strobe = (div_q == DIV_MAX);

  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_hi[i]) idx = IDX_W'(i);
    end
  end

  led7seg_decode u_decode (
    .pattern (seg_hi[SEG_G:SEG_A]),
    .nibble  (nibble),
    .match   (match)
  );

  always_comb begin
    seg_s1_d = _segments;
    seg_s2_d = seg_s1_q;
    sel_s1_d = _digit_sel;
    sel_s2_d = sel_s1_q;
    div_d    = strobe ? 16'd0 : div_q + 16'd1;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    pat_d    = pat_q;
    value_d  = value_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    error_d  = 1'b0;
    accept   = 1'b0;
`ifdef LED7SEG_DP_EN
    dp_d     = dp_q;
`endif
    if (strobe) begin
      if (!qual) begin
        cnt_d = '0;
      end else if (idx == idx_q && seg_hi == pat_q && cnt_q != '0) begin
        cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        accept = (cnt_q == STAB_M1);
      end else begin
        cnt_d  = CNT_W'(1);
        idx_d  = idx;
        pat_d  = seg_hi;
        accept = (STABLE_CNT == 1);
      end
    end
    if (accept) begin
      if (match) begin
        value_d[idx*4 +: 4] = nibble;
        valid_d[idx]        = 1'b1;
        update_d            = !valid_q[idx] || (value_q[idx*4 +: 4] != nibble);
      end else begin
        valid_d[idx] = 1'b0;
        error_d      = 1'b1;
      end
`ifdef LED7SEG_DP_EN
      dp_d[idx] = seg_hi[SEG_DP];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '1;
      seg_s2_q <= '1;
      sel_s1_q <= '1;
      sel_s2_q <= '1;
      div_q    <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      pat_q    <= '0;
      value_q  <= '0;
      valid_q  <= '0;
      update_q <= 1'b0;
      error_q  <= 1'b0;
`ifdef LED7SEG_DP_EN
      dp_q     <= '0;
`endif
    end else begin
      seg_s1_q <= seg_s1_d;
      seg_s2_q <= seg_s2_d;
      sel_s1_q <= sel_s1_d;
      sel_s2_q <= sel_s2_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pat_q    <= pat_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      error_q  <= error_d;
`ifdef LED7SEG_DP_EN
      dp_q     <= dp_d;
`endif
    end
  end

  assign value       = value_q;
  assign digit_valid = valid_q;
  assign update      = update_q;
  assign error       = error_q;
`ifdef LED7SEG_DP_EN
  assign dp          = dp_q;
`endif

endmodule

// File: tb/tb_led7seg_capture.sv
// tb/tb_led7seg_capture.sv - scoreboard bench for led7seg_capture against a sample-sequence model
module tb_led7seg_capture;

  localparam int DIGITS     = 4;
  localparam int STABLE_CNT = 3;
  localparam int SAMPLE_DIV = 16;
`ifdef LED7SEG_DP_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif

  logic                clk = 1'b0;
  logic                _reset;
  logic [SEG_W-1:0]    _segments;
  logic [DIGITS-1:0]   _digit_sel;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   digit_valid;
  logic                update, error;
`ifdef LED7SEG_DP_EN
  logic [DIGITS-1:0]   dp;
`endif

  always #5 clk = ~clk;

  led7seg_capture #(.DIGITS(DIGITS), .STABLE_CNT(STABLE_CNT), .SAMPLE_DIV(SAMPLE_DIV)) dut (
    .clk         (clk),
    ._reset      (_reset),
    ._segments   (_segments),
    ._digit_sel  (_digit_sel),
    .value       (value),
    .digit_valid (digit_valid),
    .update      (update),
    .error       (error)
`ifdef LED7SEG_DP_EN
    ,
    .dp          (dp)
`endif
  );

  typedef struct {
    bit                  is_err;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   valid;
    logic [DIGITS-1:0]   dpv;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: sequence of per-strobe samples, run length of identical qualifying samples.
  logic [4*DIGITS-1:0] m_value;
  logic [DIGITS-1:0]   m_valid, m_dp;
  int                  run, last_idx;
  logic [SEG_W-1:0]    last_pat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [SEG_W-1:0] sp(input logic [6:0] g);
    return SEG_W'(g);
  endfunction

  function automatic logic [DIGITS-1:0] one(input int d);
    return DIGITS'(1) << d;
  endfunction

  task automatic model_reset();
    m_value = '0; m_valid = '0; m_dp = '0; run = 0; last_idx = -1; last_pat = '0;
  endtask

  task automatic model_strobe(input logic [DIGITS-1:0] sel_hi, input logic [SEG_W-1:0] pat);
    int   idx, nib;
    ev_t  e;
    if ($countones(sel_hi) != 1) begin
      run = 0;
      return;
    end
    idx = 0;
    for (int i = 0; i < DIGITS; i++) if (sel_hi[i]) idx = i;
    if (run > 0 && idx == last_idx && pat == last_pat) run++;
    else begin
      run = 1; last_idx = idx; last_pat = pat;
    end
    if (run != STABLE_CNT) return;
    nib = -1;
    for (int k = 0; k < 16; k++) if (glyphs[k] == pat[6:0]) nib = k;
`ifdef LED7SEG_DP_EN
    m_dp[idx] = pat[7];
`endif
    if (nib >= 0) begin
      if (!m_valid[idx] || m_value[idx*4 +: 4] != 4'(nib)) begin
        m_value[idx*4 +: 4] = 4'(nib);
        m_valid[idx] = 1'b1;
        e.is_err = 1'b0; e.value = m_value; e.valid = m_valid; e.dpv = m_dp;
        exp_q.push_back(e);
      end
    end else begin
      m_valid[idx] = 1'b0;
      e.is_err = 1'b1; e.value = m_value; e.valid = m_valid; e.dpv = m_dp;
      exp_q.push_back(e);
    end
  endtask

  task automatic window(input logic [DIGITS-1:0] sel_hi, input logic [SEG_W-1:0] pat, input int n);
    _digit_sel = ~sel_hi;
    _segments  = ~pat;
    for (int i = 0; i < n; i++) model_strobe(sel_hi, pat);
    repeat (n * SAMPLE_DIV) @(negedge clk);
  endtask

  task automatic flush(input string tag);
    window('0, '0, 3);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_value"}, 32'(value), 32'(m_value));
    check({tag, "_valid"}, 32'(digit_valid), 32'(m_valid));
`ifdef LED7SEG_DP_EN
    check({tag, "_dp"}, 32'(dp), 32'(m_dp));
`endif
  endtask

  always @(negedge clk) begin
    if (_reset === 1'b1 && (update || error)) begin
      ev_t e;
      if (update && error) check("pulse_exclusive", 32'({update, error}), 32'b01);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got update=%0b error=%0b expected none", update, error);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind_error", 32'(error), 32'(e.is_err));
        check("pulse_value", 32'(value), 32'(e.value));
        check("pulse_valid", 32'(digit_valid), 32'(e.valid));
`ifdef LED7SEG_DP_EN
        check("pulse_dp", 32'(dp), 32'(e.dpv));
`endif
      end
    end
  end

  initial begin
    logic [4*DIGITS-1:0] snap_v;
    logic [DIGITS-1:0]   snap_ok;
    _reset = 1'b0; _segments = '1; _digit_sel = '1;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_value", 32'(value), 32'd0);
    check("reset_valid", 32'(digit_valid), 32'd0);
    check("reset_update", 32'(update), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    _reset = 1'b1;
    window('0, '0, 2);

    // "3" on digit 0
    window(one(0), sp(glyphs[3]), 3);
    flush("digit0_three");
    check("digit0_three_nibble", 32'(value[3:0]), 32'd3);
    check("digit0_three_valid", 32'(digit_valid), 32'b0001);

`ifdef LED7SEG_DP_EN
    window(one(1), {1'b1, glyphs[7]}, 3);
    flush("dp_seven");
    check("dp_seven_dp", 32'(dp), 32'b0010);
    check("dp_seven_nibble", 32'(value[7:4]), 32'd7);
`endif

    // 1,2,A,F across digits with blank gaps
    window(one(0), sp(glyphs[1]), 4);  window('0, '0, 1);
    window(one(1), sp(glyphs[2]), 4);  window('0, '0, 1);
    window(one(2), sp(glyphs[10]), 4); window('0, '0, 1);
    window(one(3), sp(glyphs[15]), 4); window('0, '0, 1);
    flush("cycle_digits");
    check("cycle_digits_value", 32'(value), 32'hFA21);
    check("cycle_digits_valid", 32'(digit_valid), 32'hF);

    // non-glyph after a held 8
    window(one(2), sp(glyphs[8]), 8);
    window(one(2), sp(7'b0000001), 3);
    flush("nonglyph");
    check("nonglyph_valid2", 32'(digit_valid[2]), 32'd0);
    check("nonglyph_nibble2", 32'(value[11:8]), 32'd8);

    // double select, then toggling pattern
    snap_v = value; snap_ok = digit_valid;
    window(4'b0011, sp(glyphs[8]), 20);
    for (int i = 0; i < 10; i++) begin
      window(one(1), sp(glyphs[1]), 1);
      window(one(1), sp(glyphs[7]), 1);
    end
    flush("no_accept");
    check("no_accept_value", 32'(value), 32'(snap_v));
    check("no_accept_valid", 32'(digit_valid), 32'(snap_ok));

    // identical re-present, then long hold accepted once
    window(one(0), sp(glyphs[1]), 3);
    window(one(3), sp(glyphs[5]), 40);
    flush("long_hold");
    check("long_hold_nibble3", 32'(value[15:12]), 32'd5);

    for (int r = 0; r < 60; r++) begin
      logic [DIGITS-1:0] s;
      logic [SEG_W-1:0]  p;
      int c;
      c = $urandom_range(0, 9);
      if (c == 0) s = '0;
      else if (c == 1) s = one($urandom_range(0, 1)) | one($urandom_range(2, 3));
      else s = one($urandom_range(0, DIGITS - 1));
      p = ($urandom_range(0, 9) < 7) ? sp(glyphs[$urandom_range(0, 15)]) : SEG_W'($urandom);
`ifdef LED7SEG_DP_EN
      p[7] = 1'($urandom);
`endif
      window(s, p, $urandom_range(1, 5));
    end
    flush("random");

    // reset in the middle of an accumulation
    window(one(1), sp(glyphs[7]), 2);
    _reset = 1'b0;
    #1;
    check("midreset_value", 32'(value), 32'd0);
    check("midreset_valid", 32'(digit_valid), 32'd0);
    check("midreset_pulses", 32'({update, error}), 32'd0);
`ifdef LED7SEG_DP_EN
    check("midreset_dp", 32'(dp), 32'd0);
`endif
    repeat (2) @(negedge clk);
    model_reset();
    exp_q.delete();
    _digit_sel = '1; _segments = '1;
    _reset = 1'b1;
    window('0, '0, 2);
    window(one(1), sp(glyphs[7]), 2);
    flush("after_reset_short");
    check("after_reset_short_valid", 32'(digit_valid), 32'd0);
    window(one(1), sp(glyphs[7]), 3);
    flush("after_reset_full");
    check("after_reset_full_nibble", 32'(value[7:4]), 32'd7);
    check("after_reset_full_valid", 32'(digit_valid), 32'b0010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led7seg_capture.md
# led7seg_capture

Captures a multiplexed, active-low seven-segment display bus and turns it back into hex digits. It samples the shared segment lines and per-digit select lines, and requires each pattern to hold across several samples before accepting it. Each accepted pattern is decoded to a nibble and stored in a per-digit register. The block sits on the input side of the plus_too debug/IO path, where it reads displays driven by our own segment drivers or by external boards.

## Interface
- DIGITS, 4, number of multiplexed digits and width of the select bus
- STABLE_CNT, 3, number of consecutive identical samples needed to accept a pattern (legal range 1..15)
- SAMPLE_DIV, 16, clocks per sample strobe (legal range 2..65535)
- clk  input  1  system clock
- _reset  input  1  asynchronous, active-low reset
- _segments  input  7 (8 with LED7SEG_DP_EN)  active-low segment lines; bit0=a … bit6=g, bit7=dp
- _digit_sel  input  DIGITS  active-low digit selects, one-hot while a digit is lit
- value  output  4*DIGITS  decoded nibbles; digit i occupies bits [4i+3:4i]
- digit_valid  output  DIGITS  digit i holds a successfully decoded pattern
- update  output  1  one-clock pulse when any value nibble changes
- error  output  1  one-clock pulse when a stable pattern is not a hex glyph
- dp  output  DIGITS  decimal point state per digit (only with LED7SEG_DP_EN)

## Operation
- _segments and _digit_sel pass through a 2-flop synchronizer and are then inverted to active-high.
- A prescaler counts 0..SAMPLE_DIV-1. The strobe is high for exactly the one clock when the count equals SAMPLE_DIV-1.
- On each strobe, the select is classified:
  - **Qualifying:** exactly one select bit set; index = position of that bit.
  - **Blank:** zero or more than one select bit set. The stability counter is forced to 0 and nothing else happens.
- Stability counter on a qualifying strobe:
  - (index, pattern) equal to the previous qualifying sample and counter nonzero: counter increments, saturating at 15.
  - Otherwise: counter loads 1, and the stored (index, pattern) is replaced.
- Accept happens on the strobe where the counter goes from STABLE_CNT-1 to STABLE_CNT. With STABLE_CNT=1, it happens on the load-1 strobe.
  - Pattern matches a glyph: value[index] and digit_valid[index] are written with the nibble and 1. If the nibble differs from the old one, or digit_valid[index] was 0, update pulses.
  - Pattern matches no glyph: digit_valid[index] is cleared, value[index] is held, and error pulses.
- Glyph table (active-high, g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- Any other pattern, including all-off, is a non-glyph.
- The saturated counter does not re-accept. A pattern that holds across many strobes is accepted exactly once.

## Timing
- Reset values: value=0, digit_valid=0, update=0, error=0, dp=0, prescaler=0, counter=0, synchronizers=all-ones (inactive).
- Reset is asynchronous assert and synchronous release. Asserting it mid-accumulation discards the count.
- value, digit_valid, update and error are registered on the clock edge that ends the accepting strobe cycle.
- update and error are single-clock pulses and never both high in the same cycle.
- Worst-case latency from a stable input change to update: 2 sync clocks + STABLE_CNT × SAMPLE_DIV clocks + 1.
- Within one strobe, a select change and a pattern change count as one mismatch: the counter loads 1.

## Configuration
- LED7SEG_DP_EN defined:
  - _segments is 8 bits and the dp output exists.
  - bit7 takes part in the stability compare.
  - On accept, dp[index] is written from bit7, for both glyph and non-glyph patterns.
  - The decimal point does not affect glyph matching.
- LED7SEG_DP_EN undefined: _segments is 7 bits, the dp port is absent, and no dp logic is present.

## Structure
- Package led7seg_pkg holds:
  - the 16 glyph constants
  - the segment bit-position constants (SEG_A..SEG_G, SEG_DP)
  - the counter width constant
- Sub-module led7seg_decode is purely combinational:
  - input: 7-bit active-high pattern
  - outputs: 4-bit nibble and a match flag
- led7seg_capture contains the synchronizer, prescaler, stability tracker and digit register file.

## Test plan
- Defaults. Drive digit 0 with "3" (active-low 7'b0110000) for 3 strobes → value[3:0]=3, digit_valid=4'b0001, one update pulse, no error.
- Cycle digits 0..3 with 1,2,A,F, each held 4 strobes with 1-strobe blank gaps → value=16'hFA21, digit_valid=4'hF, exactly 4 update pulses.
- Digit 2 shows non-glyph 7'b0000001 (active-high) for 3 strobes after holding 8 → one error pulse, digit_valid[2]=0, value[11:8]=8.
- Two selects low at once, or a pattern that toggles every strobe, for 20 strobes → no update, no error, outputs unchanged.
- Re-present an identical glyph on an already-valid digit → no update pulse; hold "5" for 40 strobes → exactly one accept.
- With LED7SEG_DP_EN: digit 1 shows "7" with dp lit for 3 strobes → dp=4'b0010, value[7:4]=7. Assert _reset mid-accumulation → all outputs 0, and 3 fresh strobes are required after release.
